// File: rtl/serial_adder_if.sv
// Handshake bundle for the bit-serial adder: operand channel, result channel
// and the busy status. master = producer/consumer side, slave = the adder.
interface serial_adder_if #(
  parameter int W = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial W-bit adder: one full-adder cell plus a registered carry, one bit
// per clock LSB first. Operands enter and the result leaves through
// valid/ready handshakes; all handshake outputs are pure state decodes.
module serial_adder #(
  parameter int W = 4
) (
  input logic           clk,
  input logic           rst,
  serial_adder_if.slave bus
);

  // Counter must hold 0..W-1; keep at least one bit so W=1 still elaborates.
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state_reg, state_next;
  logic [W-1:0]    a_sr_reg, b_sr_reg, s_sr_reg;
  logic [W-1:0]    sum_reg;
  logic            carry_reg, cout_reg;
  logic [CW-1:0]   cnt_reg;

  // Full-adder cell on the current LSBs and the registered carry.
  logic fa_sum, fa_cout;
  assign fa_sum  = a_sr_reg[0] ^ b_sr_reg[0] ^ carry_reg;
  assign fa_cout = (a_sr_reg[0] & b_sr_reg[0]) |
                   (a_sr_reg[0] & carry_reg)   |
                   (b_sr_reg[0] & carry_reg);

  // Right-shifted copies of the shift registers. Operands fill with zero,
  // the sum register takes the fresh bit at its MSB. For W=1 the loop is
  // empty and only the MSB assignment remains.
  logic [W-1:0] a_shift, b_shift, s_shift;
  genvar gi;
  generate
    for (gi = 0; gi < W - 1; gi++) begin : g_shift
      assign a_shift[gi] = a_sr_reg[gi+1];
      assign b_shift[gi] = b_sr_reg[gi+1];
      assign s_shift[gi] = s_sr_reg[gi+1];
    end
  endgenerate
  assign a_shift[W-1] = 1'b0;
  assign b_shift[W-1] = 1'b0;
  assign s_shift[W-1] = fa_sum;

  logic last_bit;
  assign last_bit = (cnt_reg == CW'(W - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state decode: accept in IDLE, run W edges, wait for the consumer.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.in_valid)  state_next = RUN;
      RUN:     if (last_bit)      state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: load on accept, shift/add one bit per RUN edge, capture result
  // on the final bit. sum/cout are otherwise held, including back in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr_reg  <= '0;
      b_sr_reg  <= '0;
      s_sr_reg  <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            a_sr_reg  <= bus.a;
            b_sr_reg  <= bus.b;
            carry_reg <= bus.cin;
            cnt_reg   <= '0;
          end
        end
        RUN: begin
          a_sr_reg  <= a_shift;
          b_sr_reg  <= b_shift;
          s_sr_reg  <= s_shift;
          carry_reg <= fa_cout;
          cnt_reg   <= cnt_reg + CW'(1);
          if (last_bit) begin
            sum_reg  <= s_shift;
            cout_reg <= fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.busy      = (state_reg == RUN);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.sum       = sum_reg;
  assign bus.cout      = cout_reg;

endmodule
